// File: rtl/ir_pulse_rate_detector.sv
// IR pulse-rate detector: hysteresis peak tracker, beat-interval counter and
// a sequential restoring divider producing BPM = floor(60*FS_HZ / interval).
module ir_pulse_rate_detector #(
  parameter int unsigned FS_HZ   = 500,
  parameter int unsigned HYST    = 1024,
  parameter int unsigned SETTLE  = 32,
  parameter int unsigned MIN_INT = 100,
  parameter int unsigned MAX_INT = 1000
) (
  input  logic        CLK_Filter,
  input  logic        rst_n,
  input  logic [19:0] IR_Filtered,
  output logic        Beat,
  output logic [8:0]  BPM,
  output logic        BPM_Valid,
  output logic        Div_Busy
);

  localparam int unsigned DATA_W  = 20;
  localparam int unsigned CMP_W   = DATA_W + 1;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned Q_W     = 15;
  localparam int unsigned BPM_W   = 9;
  localparam int unsigned ITER    = 15;
  localparam int unsigned ITER_W  = 4;
  localparam int unsigned WARM_W  = $clog2(SETTLE + 1);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned NUM     = 60 * FS_HZ;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                beat_q, beat_d;
  logic [BPM_W-1:0]    bpm_q, bpm_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [Q_W-1:0]      num_q, num_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    den_q, den_d;

  logic [CMP_W-1:0]    x_ext_c, max_ext_c, min_ext_c;
  logic                peak_c, trough_c, timeout_c, start_c;
  logic [CNT_W:0]      trial_c;
  logic                trial_ge_c;

  // 21-bit compares so the hysteresis offset can never wrap
  assign x_ext_c   = {1'b0, IR_Filtered};
  assign max_ext_c = {1'b0, max_q};
  assign min_ext_c = {1'b0, min_q};
  assign peak_c    = (state_q == RISE) && (max_ext_c > (x_ext_c + CMP_W'(HYST)));
  assign trough_c  = (state_q == FALL) && (x_ext_c > (min_ext_c + CMP_W'(HYST)));
  assign timeout_c = first_q && (cnt_q > CNT_W'(MAX_INT));
  assign start_c   = peak_c && first_q && !timeout_c && !busy_q &&
                     (cnt_q >= CNT_W'(MIN_INT)) && (cnt_q <= CNT_W'(MAX_INT));

  assign trial_c    = {rem_q, num_q[Q_W-1]};
  assign trial_ge_c = trial_c >= {1'b0, den_q};

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      warm_q  <= '0;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      beat_q  <= 1'b0;
      bpm_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      iter_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      beat_q  <= beat_d;
      bpm_q   <= bpm_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      iter_q  <= iter_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    beat_d  = 1'b0;
    bpm_d   = bpm_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    iter_d  = iter_q;
    num_d   = num_q;
    rem_d   = rem_q;
    den_d   = den_q;

    case (state_q)
      WARMUP: begin
        if (warm_q == WARM_W'(SETTLE - 1)) begin
          max_d   = IR_Filtered;
          state_d = RISE;
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      RISE: begin
        if (IR_Filtered > max_q) max_d = IR_Filtered;
        if (peak_c) begin
          min_d   = IR_Filtered;
          state_d = FALL;
        end
      end
      FALL: begin
        if (IR_Filtered < min_q) min_d = IR_Filtered;
        if (trough_c) begin
          max_d   = IR_Filtered;
          state_d = RISE;
        end
      end
      default: state_d = WARMUP;
    endcase

    if ((state_q != WARMUP) && (cnt_q != CNT_W'(CNT_MAX))) cnt_d = cnt_q + CNT_W'(1);

    // A stale beat history restarts from a fresh first peak
    if (timeout_c) begin
      first_d = 1'b0;
      valid_d = 1'b0;
    end else if (peak_c && !first_q) begin
      first_d = 1'b1;
      cnt_d   = CNT_W'(1);
    end else if (start_c) begin
      beat_d = 1'b1;
      cnt_d  = CNT_W'(1);
    end

    // Load, then 15 shift/subtract steps, then commit on the edge dropping busy
    if (start_c) begin
      busy_d = 1'b1;
      num_d  = Q_W'(NUM);
      rem_d  = '0;
      den_d  = cnt_q;
      iter_d = '0;
    end else if (busy_q) begin
      if (iter_q == ITER_W'(ITER)) begin
        busy_d  = 1'b0;
        bpm_d   = num_q[BPM_W-1:0];
        valid_d = 1'b1;
      end else begin
        rem_d  = trial_ge_c ? CNT_W'(trial_c - {1'b0, den_q}) : trial_c[CNT_W-1:0];
        num_d  = {num_q[Q_W-2:0], trial_ge_c};
        iter_d = iter_q + ITER_W'(1);
      end
    end
  end

  assign Beat      = beat_q;
  assign BPM       = bpm_q;
  assign BPM_Valid = valid_q;
  assign Div_Busy  = busy_q;

endmodule

// File: tb/tb_ir_pulse_rate_detector.sv
// Directed bench for ir_pulse_rate_detector: triangle-wave scenarios from a
// table plus hand-written flat, spike, timeout and mid-division reset cases.
module tb_ir_pulse_rate_detector;

  logic        CLK_Filter = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] IR_Filtered = '0;
  logic        Beat;
  logic [8:0]  BPM;
  logic        BPM_Valid;
  logic        Div_Busy;

  ir_pulse_rate_detector dut (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .IR_Filtered(IR_Filtered),
    .Beat       (Beat),
    .BPM        (BPM),
    .BPM_Valid  (BPM_Valid),
    .Div_Busy   (Div_Busy)
  );

  always #5 CLK_Filter = ~CLK_Filter;

  typedef struct {
    int period;
    int periods;
    bit do_reset;
    bit chk_each;
    int exp_beats;
    int exp_bpm;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int beat_count = 0;
  int last_beat_cyc = 0;
  int since_beat = -1;
  int exp_bpm = 0;
  bit chk_each = 1'b0;
  bit prev_beat = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] tri_x(input int p, input int ph, input int amp);
    int h;
    int q;
    h = p / 2;
    q = ph % p;
    if (q < h) return 20'(300000 + q * amp / h);
    return 20'(300000 + amp - (q - h) * amp / h);
  endfunction

  // One sample per call; outputs are observed 1 time unit after the edge
  task automatic step(input logic [19:0] x);
    IR_Filtered = x;
    @(posedge CLK_Filter);
    #1;
    cyc++;
    if (Beat) begin
      beat_count++;
      last_beat_cyc = cyc;
      since_beat = 0;
      chk("beat_one_cycle", int'(prev_beat), 0);
      if (chk_each) chk("busy_with_beat", int'(Div_Busy), 1);
    end else if (since_beat >= 0) begin
      since_beat++;
      if (chk_each && since_beat == 15) chk("busy_hold", int'(Div_Busy), 1);
      if (since_beat == 16) begin
        if (chk_each) begin
          chk("busy_drop", int'(Div_Busy), 0);
          chk("bpm_update", int'(BPM), exp_bpm);
          chk("valid_update", int'(BPM_Valid), 1);
        end
        since_beat = -1;
      end
    end
    prev_beat = Beat;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    IR_Filtered = '0;
    repeat (3) @(posedge CLK_Filter);
    #1;
    chk("rst_beat", int'(Beat), 0);
    chk("rst_bpm", int'(BPM), 0);
    chk("rst_valid", int'(BPM_Valid), 0);
    chk("rst_busy", int'(Div_Busy), 0);
    rst_n = 1'b1;
    cyc = 0;
    since_beat = -1;
    prev_beat = 1'b0;
  endtask

  task automatic run_tri(input int p, input int n, input int start_ph, input int amp,
                         input bit spike);
    logic [19:0] x;
    for (int i = 0; i < n; i++) begin
      x = tri_x(p, start_ph + i, amp);
      if (spike && ((start_ph + i) % p) == (p / 2 + 50)) x = x + 20'd4000;
      step(x);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[3];
    int   b0;

    vecs[0] = '{period: 500,  periods: 5, do_reset: 1'b1, chk_each: 1'b1, exp_beats: 4, exp_bpm: 60};
    vecs[1] = '{period: 250,  periods: 5, do_reset: 1'b1, chk_each: 1'b1, exp_beats: 4, exp_bpm: 120};
    vecs[2] = '{period: 1000, periods: 3, do_reset: 1'b0, chk_each: 1'b0, exp_beats: 3, exp_bpm: 30};

    // Flat input never produces a beat
    do_reset();
    chk_each = 1'b0;
    b0 = beat_count;
    repeat (2000) step(20'd300000);
    chk("flat_beats", beat_count - b0, 0);
    chk("flat_valid", int'(BPM_Valid), 0);
    chk("flat_bpm", int'(BPM), 0);

    for (int v = 0; v < 3; v++) begin
      if (vecs[v].do_reset) do_reset();
      chk_each = vecs[v].chk_each;
      exp_bpm = vecs[v].exp_bpm;
      b0 = beat_count;
      run_tri(vecs[v].period, vecs[v].period * vecs[v].periods, 0, 20000, 1'b0);
      chk($sformatf("vec%0d_beats", v), beat_count - b0, vecs[v].exp_beats);
      chk($sformatf("vec%0d_bpm", v), int'(BPM), vecs[v].exp_bpm);
      chk($sformatf("vec%0d_valid", v), int'(BPM_Valid), 1);
    end

    // Swing below the hysteresis never confirms a peak
    do_reset();
    chk_each = 1'b0;
    b0 = beat_count;
    run_tri(500, 2500, 0, 800, 1'b0);
    chk("lowamp_beats", beat_count - b0, 0);
    chk("lowamp_valid", int'(BPM_Valid), 0);

    // Spike 50 samples after each peak is too soon to count
    do_reset();
    chk_each = 1'b1;
    exp_bpm = 60;
    b0 = beat_count;
    run_tri(500, 2500, 0, 20000, 1'b1);
    chk("spike_beats", beat_count - b0, 4);
    chk("spike_bpm", int'(BPM), 60);

    // Lock at 60, then flat input until the measurement times out
    do_reset();
    chk_each = 1'b1;
    exp_bpm = 60;
    b0 = beat_count;
    run_tri(500, 1500, 0, 20000, 1'b0);
    chk("lock_beats", beat_count - b0, 2);
    chk("lock_bpm", int'(BPM), 60);
    while (cyc < last_beat_cyc + 1000) step(20'd310000);
    chk("timeout_before", int'(BPM_Valid), 1);
    step(20'd310000);
    chk("timeout_valid", int'(BPM_Valid), 0);
    chk("timeout_bpm", int'(BPM), 60);
    b0 = beat_count;
    run_tri(500, 600, 125, 20000, 1'b0);
    chk("restart_first_beats", beat_count - b0, 0);
    chk("restart_first_valid", int'(BPM_Valid), 0);
    run_tri(500, 400, 725, 20000, 1'b0);
    chk("restart_second_beats", beat_count - b0, 1);
    chk("restart_valid", int'(BPM_Valid), 1);
    chk("restart_bpm", int'(BPM), 60);

    // Reset asserted while the divider is iterating
    do_reset();
    chk_each = 1'b0;
    b0 = beat_count;
    for (int i = 0; i < 1000 && beat_count == b0; i++) step(tri_x(500, i, 20000));
    chk("mid_beat_seen", beat_count - b0, 1);
    for (int i = 0; i < 5; i++) step(tri_x(500, 764 + i, 20000));
    chk("mid_busy", int'(Div_Busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_beat", int'(Beat), 0);
    chk("mid_rst_bpm", int'(BPM), 0);
    chk("mid_rst_valid", int'(BPM_Valid), 0);
    chk("mid_rst_busy", int'(Div_Busy), 0);
    repeat (2) @(posedge CLK_Filter);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    since_beat = -1;
    prev_beat = 1'b0;
    b0 = beat_count;
    repeat (40) step(20'd310000);
    chk("post_rst_bpm", int'(BPM), 0);
    chk("post_rst_valid", int'(BPM_Valid), 0);
    chk("post_rst_busy", int'(Div_Busy), 0);
    chk("post_rst_beats", beat_count - b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
